// File: rtl/addsub_bist_pkg.sv
// Shared types and constants for the add/sub BIST controller and its golden model.
package addsub_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int unsigned FAIL_CNT_W = 16;

    // Bit positions inside the golden flag vector.
    localparam int unsigned GF_OVF  = 0;
    localparam int unsigned GF_COUT = 1;
    localparam int unsigned GF_W    = 2;

endpackage

// File: rtl/addsub_golden.sv
// Combinational reference add/sub: {cout,s} = a + (cin ? ~b : b) + cin, with signed overflow.
module addsub_golden
    import addsub_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] s_o,
    output logic [GF_W-1:0]  flags_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Overflow on the effective operand covers both add and subtract rules.
    always_comb begin
        b_eff            = cin_i ? ~b_i : b_i;
        sum              = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_i};
        s_o              = sum[WIDTH-1:0];
        flags_o          = '0;
        flags_o[GF_COUT] = sum[WIDTH];
        flags_o[GF_OVF]  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_bist_ctrl.sv
// BIST master: sweeps {cin,a,b} into an external add/sub unit and checks it against addsub_golden.
module addsub_bist_ctrl
    import addsub_bist_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned A_MAX         = 128,
    parameter int unsigned B_MAX         = 128,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          CHECK_SUB     = 1'b1,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [WIDTH-1:0]      dut_a,
    output logic [WIDTH-1:0]      dut_b,
    output logic                  dut_cin,
    input  logic [WIDTH-1:0]      dut_s,
    input  logic                  dut_cout,
    input  logic                  dut_overflow,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic [2*WIDTH:0]      first_fail
);

    localparam int unsigned SCW_RAW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned SCW     = (SCW_RAW < 1) ? 1 : SCW_RAW;
    localparam logic [SCW-1:0]   SETTLE_LAST = SCW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [WIDTH-1:0] A_LAST      = WIDTH'(A_MAX);
    localparam logic [WIDTH-1:0] B_LAST      = WIDTH'(B_MAX);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      idx_a_q, idx_a_d;
    logic [WIDTH-1:0]      idx_b_q, idx_b_d;
    logic                  idx_cin_q, idx_cin_d;
    logic [WIDTH-1:0]      dut_a_q, dut_a_d;
    logic [WIDTH-1:0]      dut_b_q, dut_b_d;
    logic                  dut_cin_q, dut_cin_d;
    logic [SCW-1:0]        settle_q, settle_d;
    logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [2*WIDTH:0]      first_fail_q, first_fail_d;
    logic                  pass_q, pass_d;

    logic [WIDTH-1:0] gold_s;
    logic [GF_W-1:0]  gold_flags;
    logic             mismatch;
    logic             last_vec;

    addsub_golden #(.WIDTH(WIDTH)) u_golden (
        .a_i     (dut_a_q),
        .b_i     (dut_b_q),
        .cin_i   (dut_cin_q),
        .s_o     (gold_s),
        .flags_o (gold_flags)
    );

    assign mismatch = (dut_s != gold_s) | (dut_cout != gold_flags[GF_COUT])
                    | (dut_overflow != gold_flags[GF_OVF]);
    assign last_vec = (idx_b_q == B_LAST) && (idx_a_q == A_LAST) && (idx_cin_q || !CHECK_SUB);

    always_comb begin
        state_d      = state_q;
        idx_a_d      = idx_a_q;
        idx_b_d      = idx_b_q;
        idx_cin_d    = idx_cin_q;
        dut_a_d      = dut_a_q;
        dut_b_d      = dut_b_q;
        dut_cin_d    = dut_cin_q;
        settle_d     = settle_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    idx_a_d      = '0;
                    idx_b_d      = '0;
                    idx_cin_d    = 1'b0;
                    fail_cnt_d   = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end
            ST_DRIVE: begin
                dut_a_d   = idx_a_q;
                dut_b_d   = idx_b_q;
                dut_cin_d = idx_cin_q;
                settle_d  = '0;
                state_d   = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    if (fail_cnt_q == '0) begin
                        first_fail_d = {dut_cin_q, dut_a_q, dut_b_q};
                    end
                end
                // pass looks at the updated count so the final vector is included.
                if (last_vec || (mismatch && STOP_ON_FAIL)) begin
                    state_d = ST_DONE;
                    pass_d  = (fail_cnt_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                    if (idx_b_q == B_LAST) begin
                        idx_b_d = '0;
                        if (idx_a_q == A_LAST) begin
                            idx_a_d   = '0;
                            idx_cin_d = 1'b1;
                        end else begin
                            idx_a_d = idx_a_q + 1'b1;
                        end
                    end else begin
                        idx_b_d = idx_b_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_a_q      <= '0;
            idx_b_q      <= '0;
            idx_cin_q    <= 1'b0;
            dut_a_q      <= '0;
            dut_b_q      <= '0;
            dut_cin_q    <= 1'b0;
            settle_q     <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_a_q      <= idx_a_d;
            idx_b_q      <= idx_b_d;
            idx_cin_q    <= idx_cin_d;
            dut_a_q      <= dut_a_d;
            dut_b_q      <= dut_b_d;
            dut_cin_q    <= dut_cin_d;
            settle_q     <= settle_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_a      = dut_a_q;
    assign dut_b      = dut_b_q;
    assign dut_cin    = dut_cin_q;
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign fail_count = fail_cnt_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_addsub_bist_ctrl.sv
// Bench for addsub_bist_ctrl: three controller instances each driving a faultable 8-bit add/sub model.
module tb_addsub_bist_ctrl;

    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       start;
    logic [2:0][7:0]  da, db, ds;
    logic [2:0]       dcin, dcout, dovf, busy, done, pass;
    logic [2:0][15:0] fc;
    logic [2:0][16:0] ff;
    int               fm [3];
    int               fk [3];
    int               total = 0;
    int               bad   = 0;

    logic [7:0] g_a, g_b, g_s;
    logic       g_cin;
    logic [1:0] g_flags;

    // Arithmetic reference: {ovf,cout,s} from integer add/subtract and signed range test.
    function automatic logic [9:0] gold(input int a, input int b, input int cin);
        int sa, sb, r, sr;
        logic [9:0] v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        if (cin == 0) begin
            r = a + b;       sr = sa + sb;
        end else begin
            r = a + 256 - b; sr = sa - sb;
        end
        v[7:0] = 8'(r % 256);
        v[8]   = (r >= 256);
        v[9]   = (sr > 127) || (sr < -128);
        return v;
    endfunction

    // Unit under test seen by the controller, with a selectable planted fault.
    function automatic logic [9:0] alu(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                       input int m, input int k);
        logic [9:0] v;
        v = gold(int'(a), int'(b), int'(cin));
        case (m)
            1: v[0] = 1'b0;
            2: v[9] = 1'b0;
            3: if (int'(a) == k) v[8] = ~v[8];
            4: if (int'(b) == k) v[7] = ~v[7];
            default: ;
        endcase
        return v;
    endfunction

    assign {dovf[0], dcout[0], ds[0]} = alu(da[0], db[0], dcin[0], fm[0], fk[0]);
    assign {dovf[1], dcout[1], ds[1]} = alu(da[1], db[1], dcin[1], fm[1], fk[1]);
    assign {dovf[2], dcout[2], ds[2]} = alu(da[2], db[2], dcin[2], fm[2], fk[2]);

    addsub_bist_ctrl #(.WIDTH(8), .A_MAX(3), .B_MAX(3), .SETTLE_CYCLES(1),
                       .CHECK_SUB(1'b1), .STOP_ON_FAIL(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .dut_a(da[0]), .dut_b(db[0]), .dut_cin(dcin[0]),
        .dut_s(ds[0]), .dut_cout(dcout[0]), .dut_overflow(dovf[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .fail_count(fc[0]), .first_fail(ff[0]));

    addsub_bist_ctrl #(.WIDTH(8), .A_MAX(3), .B_MAX(3), .SETTLE_CYCLES(1),
                       .CHECK_SUB(1'b1), .STOP_ON_FAIL(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .dut_a(da[1]), .dut_b(db[1]), .dut_cin(dcin[1]),
        .dut_s(ds[1]), .dut_cout(dcout[1]), .dut_overflow(dovf[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .fail_count(fc[1]), .first_fail(ff[1]));

    addsub_bist_ctrl #(.WIDTH(8), .A_MAX(127), .B_MAX(1), .SETTLE_CYCLES(0),
                       .CHECK_SUB(1'b0), .STOP_ON_FAIL(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .dut_a(da[2]), .dut_b(db[2]), .dut_cin(dcin[2]),
        .dut_s(ds[2]), .dut_cout(dcout[2]), .dut_overflow(dovf[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .fail_count(fc[2]), .first_fail(ff[2]));

    addsub_golden #(.WIDTH(8)) u_gold (
        .a_i(g_a), .b_i(g_b), .cin_i(g_cin), .s_o(g_s), .flags_o(g_flags));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected run outcome from sweeping every vector through reference and faulty unit.
    task automatic model(input int amax, input int bmax, input int sub, input int m, input int k,
                         output int cnt, output logic [16:0] first);
        cnt   = 0;
        first = '0;
        for (int c = 0; c <= sub; c++)
            for (int a = 0; a <= amax; a++)
                for (int b = 0; b <= bmax; b++)
                    if (alu(8'(a), 8'(b), 1'(c), m, k) !== gold(a, b, c)) begin
                        if (cnt == 0) first = {1'(c), 8'(a), 8'(b)};
                        cnt++;
                    end
    endtask

    // Start instance k, optionally pulse start again mid-run, count edges until done.
    task automatic run(input int k, input int pulse_at, output int n);
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        check("busy_after_accept", 32'(busy[k]), 32'd1);
        check("done_clear_on_accept", 32'(done[k]), 32'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            start[k] = (n == pulse_at);
        end while (!done[k] && n < LIMIT);
        start[k] = 1'b0;
        check("run_finished", 32'(n < LIMIT), 32'd1);
    endtask

    task automatic check_reset(input int k);
        check("rst_dut_a", 32'(da[k]), 32'd0);
        check("rst_dut_b", 32'(db[k]), 32'd0);
        check("rst_dut_cin", 32'(dcin[k]), 32'd0);
        check("rst_busy", 32'(busy[k]), 32'd0);
        check("rst_done", 32'(done[k]), 32'd0);
        check("rst_pass", 32'(pass[k]), 32'd0);
        check("rst_fail_count", 32'(fc[k]), 32'd0);
        check("rst_first_fail", 32'(ff[k]), 32'd0);
    endtask

    initial begin
        int          n, cnt;
        logic [16:0] first;
        logic [9:0]  want;

        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 3; i++) begin fm[i] = 0; fk[i] = 0; end
        g_a = '0; g_b = '0; g_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(2);
        rst = 1'b0;

        // Golden block: directed corner vectors, then random vectors against arithmetic.
        g_a = 8'd127; g_b = 8'd1; g_cin = 1'b0; #1;
        check("gold_127p1", 32'({g_flags[0], g_flags[1], g_s}), 32'h280);
        g_a = 8'd0; g_b = 8'd1; g_cin = 1'b1; #1;
        check("gold_0m1", 32'({g_flags[0], g_flags[1], g_s}), 32'h0FF);
        g_a = 8'd5; g_b = 8'd3; g_cin = 1'b1; #1;
        check("gold_5m3", 32'({g_flags[0], g_flags[1], g_s}), 32'h102);
        for (int i = 0; i < 16; i++) begin
            g_a = 8'($urandom); g_b = 8'($urandom); g_cin = 1'($urandom); #1;
            want = gold(int'(g_a), int'(g_b), int'(g_cin));
            check("gold_rand", 32'({g_flags[0], g_flags[1], g_s}), 32'(want));
        end

        // Clean sweep of 32 vectors at 3 cycles each.
        run(0, -1, n);
        check("t1_cycles", 32'(n), 32'd96);
        check("t1_pass", 32'(pass[0]), 32'd1);
        check("t1_fail_count", 32'(fc[0]), 32'd0);
        check("t1_first_fail", 32'(ff[0]), 32'd0);
        check("t1_hold_vector", 32'({dcin[0], da[0], db[0]}), 32'h10303);

        // s[0] stuck at 0: every odd result fails.
        fm[0] = 1;
        run(0, -1, n);
        check("t2_cycles", 32'(n), 32'd96);
        check("t2_fail_count", 32'(fc[0]), 32'd16);
        check("t2_first_fail", 32'(ff[0]), 32'h00001);
        check("t2_pass", 32'(pass[0]), 32'd0);

        // Overflow stuck at 0: only 127+1 overflows in this sweep.
        fm[2] = 2;
        run(2, -1, n);
        check("t3_cycles", 32'(n), 32'd512);
        check("t3_fail_count", 32'(fc[2]), 32'd1);
        check("t3_first_fail", 32'(ff[2]), 32'h07F01);
        check("t3_pass", 32'(pass[2]), 32'd0);

        // Stop on first failure at vector index 1 (DRIVE at edge 3, DONE at edge 6).
        fm[1] = 1;
        run(1, -1, n);
        check("t5_cycles", 32'(n), 32'd6);
        check("t5_fail_count", 32'(fc[1]), 32'd1);
        check("t5_first_fail", 32'(ff[1]), 32'h00001);
        check("t5_pass", 32'(pass[1]), 32'd0);

        // Random faults, with a stray start pulse during each run.
        for (int it = 0; it < 8; it++) begin
            fm[0] = int'($urandom_range(0, 4));
            fk[0] = int'($urandom_range(0, 3));
            model(3, 3, 1, fm[0], fk[0], cnt, first);
            run(0, int'($urandom_range(5, 80)), n);
            check("rnd_cycles", 32'(n), 32'd96);
            check("rnd_fail_count", 32'(fc[0]), 32'(cnt));
            check("rnd_first_fail", 32'(ff[0]), 32'(first));
            check("rnd_pass", 32'(pass[0]), 32'(cnt == 0));
        end

        // Reset in the middle of a faulty run, then a clean run.
        fm[0] = 1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset(0);
        rst = 1'b0;
        fm[0] = 0;
        run(0, 40, n);
        check("t6_cycles", 32'(n), 32'd96);
        check("t6_pass", 32'(pass[0]), 32'd1);
        check("t6_fail_count", 32'(fc[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
